// File: rtl/uart_cmd_parser.sv
// UART command parser: collects 0x55/ADDR/LEN/payload/CSUM frames from a byte stream
// and replays the verified payload as a burst of address/data write beats.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 2048
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_rdy,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_wr_en,
  input  logic       i_wr_ready,
  output logic       o_busy,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code
);

  localparam int unsigned LEN_W = 4;
  localparam int unsigned IDX_W = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);
  localparam int unsigned BUF_D = 1 << IDX_W;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_HUNT,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_WRITE
  } state_e;

  state_e           state_q, state_d;
  logic             rdy_q;
  logic [7:0]       base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       buf_q [BUF_D];
  logic [7:0]       buf_d [BUF_D];
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic byte_evt_c;
  logic timed_c;
  logic [LEN_W-1:0] idx_inc_c;

  assign byte_evt_c = i_rx_rdy & ~rdy_q;
  assign timed_c    = (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign idx_inc_c  = idx_q + LEN_W'(1);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    tmo_d       = '0;
    buf_d       = buf_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      S_HUNT: begin
        if (byte_evt_c && (i_rx_data == 8'h55)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (byte_evt_c) begin
          base_d  = i_rx_data;
          sum_d   = i_rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (byte_evt_c) begin
          if ((i_rx_data == 8'd0) || (i_rx_data > 8'(MAX_LEN))) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_HUNT;
          end else begin
            len_d   = LEN_W'(i_rx_data);
            idx_d   = '0;
            sum_d   = sum_q + i_rx_data;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (byte_evt_c) begin
          buf_d[IDX_W'(idx_q)] = i_rx_data;
          sum_d = sum_q + i_rx_data;
          idx_d = idx_inc_c;
          if (idx_inc_c == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (byte_evt_c) begin
          if (i_rx_data == sum_q) begin
            idx_d     = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = buf_q[IDX_W'(0)];
            state_d   = S_WRITE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = S_HUNT;
          end
        end
      end
      S_WRITE: begin
        // Received bytes are ignored here; only sink acceptance advances the burst
        if (wr_en_q && i_wr_ready) begin
          if (idx_inc_c == len_q) begin
            wr_en_d    = 1'b0;
            frame_ok_d = 1'b1;
            err_code_d = ERR_OK;
            state_d    = S_HUNT;
          end else begin
            idx_d     = idx_inc_c;
            wr_addr_d = base_q + 8'(idx_inc_c);
            wr_data_d = buf_q[IDX_W'(idx_inc_c)];
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    // A byte arriving on the expiry cycle takes precedence over the timeout
    if (timed_c && !byte_evt_c) begin
      if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        err_code_d  = ERR_TMO;
        state_d     = S_HUNT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    busy_d = (state_d != S_HUNT);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_HUNT;
      rdy_q       <= 1'b1;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_OK;
    end else begin
      state_q     <= state_d;
      rdy_q       <= i_rx_rdy;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload storage carries no reset
  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_busy      = busy_q;
  assign o_frame_ok  = frame_ok_q;
  assign o_frame_err = frame_err_q;
  assign o_err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames plus randomized frames scored against
// expectations built from the frame contents (writes, result pulse, code).
module tb_uart_cmd_parser;

  localparam int unsigned MAX_LEN     = 8;
  localparam int unsigned TIMEOUT_CYC = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy = 1'b1;
  logic [7:0] wr_addr, wr_data;
  logic       wr_en;
  logic       wr_ready = 1'b1;
  logic       busy, frame_ok, frame_err;
  logic [1:0] err_code;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_rdy(rx_rdy),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_wr_en(wr_en), .i_wr_ready(wr_ready),
    .o_busy(busy), .o_frame_ok(frame_ok), .o_frame_err(frame_err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sink ready pattern: 0 always ready, 1 toggle, 2 random, 3 stalled
  int unsigned rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = ~wr_ready;
      2:       wr_ready = 1'($urandom_range(0, 1));
      default: wr_ready = 1'b0;
    endcase
  end

  // Observed traffic
  logic [15:0] wr_q[$];
  int unsigned wr_cyc_q[$];
  logic [2:0]  res_q[$];
  int unsigned res_cyc_q[$];
  logic        hold_pend = 1'b0;
  logic [16:0] hold_val;
  logic        ok_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      ok_prev   = 1'b0;
      err_prev  = 1'b0;
    end else begin
      if (hold_pend) check("beat_hold", {wr_en, wr_addr, wr_data}, hold_val);
      hold_pend = wr_en && !wr_ready;
      hold_val  = {wr_en, wr_addr, wr_data};
      if (wr_en && wr_ready) begin
        wr_q.push_back({wr_addr, wr_data});
        wr_cyc_q.push_back(cyc);
      end
      if (frame_ok || frame_err) begin
        check("pulse_shape", {29'd0, frame_ok & frame_err, frame_ok & ok_prev, frame_err & err_prev}, 0);
        res_q.push_back({frame_ok, err_code});
        res_cyc_q.push_back(cyc);
      end
      ok_prev  = frame_ok;
      err_prev = frame_err;
    end
  end

  int unsigned gap_max = 0;
  int unsigned last_edge = 0;
  int unsigned csum_edge = 0;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk); #1;
    last_edge = cyc;
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, gap_max)) @(posedge clk);
  endtask

  task automatic clear_obs();
    wr_q.delete(); wr_cyc_q.delete(); res_q.delete(); res_cyc_q.delete();
  endtask

  task automatic wait_result(input int unsigned budget);
    int unsigned n = 0;
    while (res_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
  endtask

  // Expected outcome derived from frame contents: legal length + matching checksum
  // writes payload[i] to addr+i and reports ok; otherwise a single error result.
  task automatic run_frame(input logic [7:0] addr, input logic [7:0] len, input logic [7:0] pl[$],
                           input logic [7:0] csum_delta, input logic [7:0] noise[$],
                           input int unsigned mode, input string tag);
    logic [15:0] exp_wr[$];
    logic [1:0]  exp_code;
    logic [7:0]  sum;
    rdy_mode = mode;
    clear_obs();
    foreach (noise[k]) send_byte(noise[k]);
    send_byte(8'h55);
    send_byte(addr);
    send_byte(len);
    if (len == 8'd0 || len > 8'(MAX_LEN)) begin
      exp_code = 2'b10;
    end else begin
      sum = addr + len;
      for (int i = 0; i < int'(len); i++) begin
        sum = sum + pl[i];
        exp_wr.push_back({addr + 8'(i), pl[i]});
        send_byte(pl[i]);
      end
      exp_code = (csum_delta == 8'd0) ? 2'b00 : 2'b01;
      if (csum_delta != 8'd0) exp_wr.delete();
      send_byte(sum + csum_delta);
      csum_edge = last_edge;
    end
    wait_result(400);
    check({tag, "_nres"}, res_q.size(), 1);
    if (res_q.size() > 0) check({tag, "_res"}, 32'(res_q[0]), {29'd0, exp_code == 2'b00, exp_code});
    check({tag, "_nwr"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      check({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
    check({tag, "_code"}, 32'(err_code), 32'(exp_code));
    check({tag, "_busy"}, 32'(busy), 0);
    rdy_mode = 0;
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] nz[$];
    logic [7:0] len, addr, b;
    int unsigned kind;

    // Reset with receiver level held high and a header on the bus
    rx_data = 8'h55;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outs", {wr_en, wr_addr, wr_data, busy, frame_ok, frame_err, err_code},
          0);
    repeat (5) @(negedge clk);
    check("rdy_high_no_evt", 32'(busy), 0);
    rx_rdy = 1'b0;
    repeat (2) @(posedge clk);

    // Basic two-beat frame with back-to-back beats
    pl = '{8'hA1, 8'hB2}; nz.delete();
    run_frame(8'h10, 8'h02, pl, 8'h00, nz, 0, "basic");
    if (wr_cyc_q.size() == 2 && res_cyc_q.size() == 1) begin
      check("first_beat_lat", wr_cyc_q[0] - csum_edge, 0);
      check("beats_consec", wr_cyc_q[1] - wr_cyc_q[0], 1);
      check("ok_after_last", res_cyc_q[0] - wr_cyc_q[1], 1);
    end else check("basic_timing_obs", {wr_cyc_q.size(), res_cyc_q.size()} , {32'd2, 32'd1});

    // Checksum error, then a valid frame
    run_frame(8'h10, 8'h02, pl, 8'h01, nz, 0, "bad_csum");
    run_frame(8'h10, 8'h02, pl, 8'h00, nz, 0, "after_csum");

    // Address wrap with toggling ready
    pl = '{8'h01, 8'h02};
    run_frame(8'hFF, 8'h02, pl, 8'h00, nz, 1, "wrap_toggle");

    // Length bounds
    run_frame(8'h20, 8'h00, pl, 8'h00, nz, 0, "len_zero");
    run_frame(8'h20, 8'h09, pl, 8'h00, nz, 0, "len_big");
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(8'h80, 8'h08, pl, 8'h00, nz, 2, "len_max");

    // Noise before header
    pl = '{8'h7E}; nz = '{8'h00, 8'hAA};
    run_frame(8'h30, 8'h01, pl, 8'h00, nz, 0, "noise");
    nz.delete();

    // Inter-byte timeout
    clear_obs();
    send_byte(8'h55);
    send_byte(8'h20);
    wait_result(TIMEOUT_CYC + 200);
    check("tmo_nres", res_q.size(), 1);
    if (res_q.size() > 0) begin
      check("tmo_res", 32'(res_q[0]), 32'(3'b011));
      check("tmo_lat", res_cyc_q[0] - last_edge, TIMEOUT_CYC);
    end
    check("tmo_busy", 32'(busy), 0);
    check("tmo_nwr", wr_q.size(), 0);

    // Byte landing on the expiry cycle keeps the frame alive
    clear_obs();
    send_byte(8'h55);
    send_byte(8'h20);
    repeat (TIMEOUT_CYC - 2) @(posedge clk);
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'h7B);
    wait_result(100);
    check("race_nres", res_q.size(), 1);
    if (res_q.size() > 0) check("race_res", 32'(res_q[0]), 32'(3'b100));
    check("race_nwr", wr_q.size(), 1);
    if (wr_q.size() > 0) check("race_wr", 32'(wr_q[0]), 32'h205A);

    // Bytes during a stalled burst are dropped
    clear_obs();
    rdy_mode = 3;
    send_byte(8'h55); send_byte(8'h40); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h75);
    send_byte(8'h55); send_byte(8'h99);
    rdy_mode = 0;
    wait_result(100);
    check("drop_nres", res_q.size(), 1);
    if (res_q.size() > 0) check("drop_res", 32'(res_q[0]), 32'(3'b100));
    check("drop_nwr", wr_q.size(), 2);
    if (wr_q.size() == 2) check("drop_wr", {wr_q[0], wr_q[1]}, 32'h4011_4122);
    check("drop_busy", 32'(busy), 0);

    // Reset in the middle of a stalled burst
    clear_obs();
    rdy_mode = 3;
    send_byte(8'h55); send_byte(8'h50); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h59);
    repeat (3) @(negedge clk);
    check("stall_en", 32'(wr_en), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rdy_mode = 0;
    repeat (20) @(negedge clk);
    check("rst_wr_nwr", wr_q.size(), 0);
    check("rst_wr_nres", res_q.size(), 0);
    check("rst_wr_outs", {wr_en, wr_addr, wr_data, busy, err_code}, 0);

    // Reset mid-frame leaves no pending timeout
    clear_obs();
    send_byte(8'h55); send_byte(8'h60);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (TIMEOUT_CYC + 50) @(negedge clk);
    check("rst_frm_nres", res_q.size(), 0);
    check("rst_frm_busy", 32'(busy), 0);

    // Randomized frames
    gap_max = 3;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hF8, 8'hFF)) : 8'($urandom);
      len  = 8'($urandom_range(1, MAX_LEN));
      if (kind == 0) len = 8'h00;
      if (kind == 1) len = 8'($urandom_range(MAX_LEN + 1, 255));
      pl.delete();
      for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
      nz.delete();
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h00;
        nz.push_back(b);
      end
      run_frame(addr, len, pl, (kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00, nz,
                $urandom_range(0, 2), $sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum payload bytes per frame (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2048, the inter-byte timeout in i_clk cycles.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_rx_data  input  8  received byte from the UART receiver; valid while i_rx_rdy is high.
REQ-006 SHALL have port i_rx_rdy  input  1  receiver frame-done level; a new byte is signalled by a 0->1 transition.
REQ-007 SHALL have port o_wr_addr  output  8  write address.
REQ-008 SHALL have port o_wr_data  output  8  write data.
REQ-009 SHALL have port o_wr_en  output  1  write request.
REQ-010 SHALL have port i_wr_ready  input  1  sink accepts the beat when o_wr_en and i_wr_ready are both high.
REQ-011 SHALL have port o_busy  output  1  high whenever the FSM is not in HUNT.
REQ-012 SHALL have port o_frame_ok  output  1  one-cycle pulse after a frame is fully written.
REQ-013 SHALL have port o_frame_err  output  1  one-cycle pulse when a frame is rejected.
REQ-014 SHALL have port o_err_code  output  2  result code: 00 ok, 01 checksum, 10 length, 11 timeout; held until the next frame result.

Function
REQ-015 Byte event: rdy_q register tracks i_rx_rdy; byte_evt = i_rx_rdy & ~rdy_q; the FSM acts on byte_evt at the same clock edge.
REQ-016 rdy_q SHALL reset to 1, so a receiver that holds i_rx_rdy high out of reset produces no event.
REQ-017 Frame format: 0x55 header, ADDR, LEN, LEN payload bytes, CSUM.
REQ-018 CSUM = (ADDR + LEN + sum of payload) mod 256.
REQ-019 FSM states: HUNT, ADDR, LEN, PAYLOAD, CSUM, WRITE.
REQ-020 HUNT: byte 0x55 -> ADDR; any other byte is discarded silently with no pulse.
REQ-021 ADDR: latch the byte as the base address, then go to LEN.
REQ-022 LEN: if LEN==0 or LEN>MAX_LEN, pulse o_frame_err, set code 10 and go to HUNT; otherwise latch LEN, clear the payload index, go to PAYLOAD.
REQ-023 PAYLOAD: store each byte in buf[index] (MAX_LEN x 8 register buffer), index+1; after byte LEN go to CSUM.
REQ-024 CSUM: a running 8-bit sum is accumulated from ADDR onward.
REQ-025 CSUM on match: go to WRITE with beat index 0.
REQ-026 CSUM on mismatch: pulse o_frame_err, set code 01, go to HUNT; no write is issued.
REQ-027 WRITE: o_wr_en=1, o_wr_addr=(base+i) mod 256, o_wr_data=buf[i].
REQ-028 WRITE: all three outputs SHALL be held stable until accepted; on acceptance i+1 and the next beat is presented the following cycle.
REQ-029 First write beat SHALL appear the cycle after the CSUM byte edge; with i_wr_ready tied high, LEN beats occur on consecutive cycles.
REQ-030 After the last accepted beat: o_wr_en=0, o_frame_ok pulses the next cycle, code 00, state HUNT.
REQ-031 Byte events arriving during WRITE SHALL be dropped; the frame in progress is unaffected.
REQ-032 Timeout: in ADDR/LEN/PAYLOAD/CSUM, a counter clears on every byte_evt and on state entry.
REQ-033 If the timeout counter reaches TIMEOUT_CYC-1 without a byte, pulse o_frame_err, set code 11, go to HUNT.
REQ-034 The timeout counter SHALL be inactive in HUNT and WRITE.
REQ-035 Timeout and byte_evt in the same cycle: the byte wins; no timeout.
REQ-036 o_frame_ok and o_frame_err SHALL never be high together; each pulse is exactly 1 cycle.
REQ-037 Address wrap is modulo 256 with no error.

Reset
REQ-038 On i_reset=1 at a clock edge: state HUNT, rdy_q=1, counters/index/sum=0.
REQ-039 On reset, outputs SHALL be o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_frame_ok=0, o_frame_err=0, o_err_code=00; buffer contents are don't-care.
REQ-040 Reset asserted mid-frame or mid-WRITE SHALL abort immediately with no further beats and no pulses.

Verification
REQ-041 Bytes 55 10 02 A1 B2 65, wr_ready=1 -> writes (10,A1),(11,B2) on consecutive cycles, then frame_ok pulse, code 00.
REQ-042 Bytes 55 10 02 A1 B2 66 -> no o_wr_en, frame_err pulse, code 01; a following valid frame is accepted.
REQ-043 Bytes 55 FF 02 01 02 04, wr_ready toggling 1/0 -> beats (FF,01),(00,02), each held stable while ready=0.
REQ-044 Bytes 55 20 00 and, separately, 55 20 09 -> frame_err, code 10 in both cases.
REQ-045 Bytes 55 20 then idle for 2048 cycles -> frame_err, code 11, o_busy falls.
REQ-046 Noise: 00 AA 55 30 01 7E AF -> bytes 00 and AA ignored, single write (30,7E), frame_ok.
